// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared constants for the two-input gate BIST controller.
//   - func_sel codes for the expected gate function
//   - FSM state encoding
//   - illegal func_sel check
package gate_bist_pkg;

  typedef logic [2:0] func_t;
  typedef logic [2:0] state_t;

  localparam func_t FN_AND  = 3'd0;
  localparam func_t FN_OR   = 3'd1;
  localparam func_t FN_NAND = 3'd2;
  localparam func_t FN_NOR  = 3'd3;
  localparam func_t FN_XOR  = 3'd4;
  localparam func_t FN_XNOR = 3'd5;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_APPLY  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // Codes 6 and 7 have no gate behind them.
  function automatic logic func_illegal(input func_t f);
    return f > FN_XNOR;
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// gate_bist_ctrl_if: control/status and gate-under-test signals of the BIST.
//   slave  : the controller (takes start/func_sel/dut_c, drives the rest)
//   master : whoever launches runs and hosts the gate under test
interface gate_bist_ctrl_if;
  import gate_bist_pkg::*;

  logic        start;
  func_t       func_sel;
  logic        dut_a;
  logic        dut_b;
  logic        dut_c;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  err_count;
  logic [3:0]  err_vec;

  modport slave (
    input  start, func_sel, dut_c,
    output dut_a, dut_b, busy, done, pass, err_count, err_vec
  );

  modport master (
    output start, func_sel, dut_c,
    input  dut_a, dut_b, busy, done, pass, err_count, err_vec
  );
endinterface

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden model of the gate under test.
//   a, b : stimulus bits
//   func : function code (gate_bist_pkg FN_*)
//   c    : expected gate output (0 for illegal codes; never checked then)
module gate_ref_model
  import gate_bist_pkg::*;
(
  input  logic  a,
  input  logic  b,
  input  func_t func,
  output logic  c
);
  always_comb begin
    c = 1'b0;
    case (func)
      FN_AND:  c = a & b;
      FN_OR:   c = a | b;
      FN_NAND: c = ~(a & b);
      FN_NOR:  c = ~(a | b);
      FN_XOR:  c = a ^ b;
      FN_XNOR: c = ~(a ^ b);
      default: c = 1'b0;
    endcase
  end
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: exhaustive BIST of a two-input gate.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : gate_bist_ctrl_if.slave (start/func_sel in, dut_a/dut_b out,
//              dut_c in, busy/done/pass/err_count/err_vec status out)
// Each of the four vectors {a,b}=0..3 is applied for one APPLY cycle, held
// for SETTLE_CYCLES, then compared in CHECK against gate_ref_model.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1   // 1..15
) (
  input  logic           clk,
  input  logic           rst,
  gate_bist_ctrl_if.slave bus
);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  func_t      func_q;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [2:0] err_count;
  logic [3:0] err_vec;
  logic       pass;
  logic       exp_c;
  logic       mismatch;
  logic       active;

  gate_ref_model u_ref (
    .a    (idx[1]),
    .b    (idx[0]),
    .func (func_q),
    .c    (exp_c)
  );

  // Written as "mismatch unless provably equal" so an X/Z response falls
  // through the if and counts as an error.
  always_comb begin
    mismatch = 1'b1;
    if (bus.dut_c == exp_c) mismatch = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      func_q    <= FN_AND;
      idx       <= 2'd0;
      cnt       <= 4'd0;
      err_count <= 3'd0;
      err_vec   <= 4'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          func_q <= bus.func_sel;
          idx    <= 2'd0;
          pass   <= 1'b0;
          if (func_illegal(bus.func_sel)) begin
            // Nothing meaningful to test: report every vector as failed.
            err_count <= 3'd4;
            err_vec   <= 4'hF;
            state     <= ST_DONE;
          end else begin
            err_count <= 3'd0;
            err_vec   <= 4'd0;
            state     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          cnt   <= 4'd0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) state <= ST_CHECK;
          else                    cnt   <= cnt + 4'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_vec[idx] <= 1'b1;
            err_count    <= err_count + 3'd1;
          end
          // idx saturates at 3: the run ends instead of wrapping.
          if (idx == 2'd3) state <= ST_DONE;
          else begin
            idx   <= idx + 2'd1;
            state <= ST_APPLY;
          end
        end
        ST_DONE: begin
          pass  <= (err_count == 3'd0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stimulus is only driven while a vector is in flight; outputs decode
  // straight from state so reset clears them without waiting for a clock.
  assign active        = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
  assign bus.dut_a     = active & idx[1];
  assign bus.dut_b     = active & idx[0];
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.pass      = pass;
  assign bus.err_count = err_count;
  assign bus.err_vec   = err_vec;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: directed test of gate_bist_ctrl with SETTLE_CYCLES=1.
// Cycle i of a run is the clock period after the i-th rising edge following
// the edge that accepted start; outputs are sampled on the falling edge.
// With SETTLE_CYCLES=1 each vector occupies 3 cycles, so done is seen at i=13.
module tb_gate_bist_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   gate_mode;   // 0 NAND, 1 AND, 2 stuck-at-0
  logic gate_c;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [1:0] vecs [0:63];

  gate_bist_ctrl_if bus ();

  gate_bist_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    gate_c = 1'b0;
    case (gate_mode)
      0:       gate_c = ~(bus.dut_a & bus.dut_b);
      1:       gate_c = bus.dut_a & bus.dut_b;
      default: gate_c = 1'b0;
    endcase
  end
  assign bus.dut_c = gate_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one run; returns the cycle index at which done was seen (0 = never).
  task automatic run(input logic [2:0] f, input int mode, output int lat);
    @(negedge clk);
    bus.func_sel = f;
    gate_mode    = mode;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.func_sel = ~f;   // must have been latched already
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      vecs[i] = {bus.dut_a, bus.dut_b};
      if (i == 1) chk("pass_cleared_on_start", bus.pass, 0);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
    chk("done_single_cycle", bus.done, 0);
    chk("busy_low_after_run", bus.busy, 0);
  endtask

  initial begin
    int         lat;
    int         pulses;
    int         first_done;
    int         second_done;
    logic [23:0] seq;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.func_sel = 3'd0;
    gate_mode    = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_done",      bus.done, 0);
    chk("rst_pass",      bus.pass, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_err_vec",   bus.err_vec, 0);
    chk("rst_ab",        {bus.dut_a, bus.dut_b}, 0);
    rst = 1'b0;

    // NAND expected, correct NAND attached: vectors in order, done at 13.
    run(3'd2, 0, lat);
    chk("nand_ok_latency", lat, 13);
    seq = '0;
    for (int i = 1; i <= 12; i++) seq = {seq[21:0], vecs[i]};
    chk("nand_ok_vec_order", seq, 24'b000000_010101_101010_111111);
    chk("nand_ok_ab_in_done", vecs[13], 0);
    chk("nand_ok_pass",      bus.pass, 1);
    chk("nand_ok_err_count", bus.err_count, 0);
    chk("nand_ok_err_vec",   bus.err_vec, 0);

    // NAND expected, AND attached: every vector wrong.
    run(3'd2, 1, lat);
    chk("nand_vs_and_latency",   lat, 13);
    chk("nand_vs_and_pass",      bus.pass, 0);
    chk("nand_vs_and_err_count", bus.err_count, 4);
    chk("nand_vs_and_err_vec",   bus.err_vec, 4'b1111);

    // XOR expected, output stuck at 0: vectors 1 and 2 fail.
    run(3'd4, 2, lat);
    chk("xor_sa0_pass",      bus.pass, 0);
    chk("xor_sa0_err_count", bus.err_count, 2);
    chk("xor_sa0_err_vec",   bus.err_vec, 4'b0110);

    // Illegal code: straight to DONE in the first cycle, stimulus stays 0.
    run(3'd7, 0, lat);
    chk("illegal_latency",   lat, 1);
    chk("illegal_ab",        vecs[1], 0);
    chk("illegal_pass",      bus.pass, 0);
    chk("illegal_err_count", bus.err_count, 4);
    chk("illegal_err_vec",   bus.err_vec, 4'b1111);

    // start held high: runs are back to back via one IDLE cycle, one done each.
    @(negedge clk);
    bus.func_sel = 3'd2;
    gate_mode    = 0;
    bus.start    = 1'b1;
    @(posedge clk);
    pulses = 0; first_done = 0; second_done = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (pulses == 1) first_done = i;
        if (pulses == 2) second_done = i;
      end
    end
    bus.start = 1'b0;
    chk("hold_done_pulses", pulses, 2);
    chk("hold_first_done",  first_done, 13);
    chk("hold_second_done", second_done, 27);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("hold_returns_idle", bus.busy, 0);
    chk("hold_pass",         bus.pass, 1);

    // Reset during SETTLE of vector 2 (cycle 8), AND attached to accumulate errors.
    @(negedge clk);
    bus.func_sel = 3'd2;
    gate_mode    = 1;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 8; i++) @(negedge clk);
    chk("midrun_ab",        {bus.dut_a, bus.dut_b}, 2'b10);
    chk("midrun_err_count", bus.err_count, 2);
    chk("midrun_err_vec",   bus.err_vec, 4'b0011);
    rst = 1'b1;
    #1;
    chk("abort_busy",      bus.busy, 0);
    chk("abort_ab",        {bus.dut_a, bus.dut_b}, 0);
    chk("abort_err_count", bus.err_count, 0);
    chk("abort_err_vec",   bus.err_vec, 0);
    chk("abort_done",      bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run(3'd2, 0, lat);
    chk("after_abort_latency", lat, 13);
    chk("after_abort_pass",    bus.pass, 1);
    chk("after_abort_err_vec", bus.err_vec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
